// File: rtl/mips_pkg.sv
// Shared encodings and defaults for the MIPS core front end.
package mips_pkg;

  localparam logic [1:0] REDIR_BR  = 2'b00;
  localparam logic [1:0] REDIR_J   = 2'b01;
  localparam logic [1:0] REDIR_JR  = 2'b10;
  localparam logic [1:0] REDIR_RSV = 2'b11;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target selection: exception first, then branch/jump/jump-register.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        exc_req,
  input  logic        redir_valid,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_pc_plus4,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_jr,
  output logic        take,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] branch_offset;

  assign branch_offset = {{14{redir_imm[15]}}, redir_imm, 2'b00};

  // Reserved type without an exception leaves take low so the fetch stream is untouched.
  always_comb begin
    take       = 1'b0;
    target     = EXC_VECTOR;
    misaligned = 1'b0;
    if (exc_req) begin
      take = 1'b1;
    end else if (redir_valid) begin
      case (redir_type)
        REDIR_BR: begin
          take   = 1'b1;
          target = redir_pc_plus4 + branch_offset;
        end
        REDIR_J: begin
          take   = 1'b1;
          target = {redir_pc_plus4[31:28], redir_index, 2'b00};
        end
        REDIR_JR: begin
          take       = 1'b1;
          target     = redir_jr;
          misaligned = |redir_jr[1:0];
        end
        default: begin
          take = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction fetch sequencer with a one-entry buffer toward decode.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_pc_plus4,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_jr,
  input  logic        exc_req,
  output logic        addr_err
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  drop_addr;
  logic         drop_pending;
  logic         buf_free;
  logic         accept;
  logic         redir_take;
  logic         redir_misaligned;
  logic [31:0]  redir_target;

  pc_target_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_target (
    .exc_req        (exc_req),
    .redir_valid    (redir_valid),
    .redir_type     (redir_type),
    .redir_pc_plus4 (redir_pc_plus4),
    .redir_imm      (redir_imm),
    .redir_index    (redir_index),
    .redir_jr       (redir_jr),
    .take           (redir_take),
    .target         (redir_target),
    .misaligned     (redir_misaligned)
  );

  assign pc_plus4 = pc + 32'd4;
  assign buf_free = !if_valid || id_ready;

  // A request is only raised when its response is guaranteed a slot in the buffer;
  // while a discarded fetch is in flight the address of that old request is held.
  always_comb begin
    imem_req   = (state == FETCH) && buf_free;
    imem_addr  = drop_pending ? drop_addr : pc;
    accept     = imem_req && imem_ready && !drop_pending && !redir_take;
    state_next = state;
    case (state)
      BOOT:    state_next = FETCH;
      FETCH:   if (!buf_free) state_next = HOLD;
      HOLD:    if (id_ready) state_next = FETCH;
      default: state_next = BOOT;
    endcase
    if (redir_take) state_next = FETCH;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Redirects flush the buffer; an unanswered request becomes a pending drop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      drop_pending <= 1'b0;
      drop_addr    <= 32'h0;
      addr_err     <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= 32'h0;
      if_pc        <= 32'h0;
      if_pc_plus4  <= 32'h0;
    end else begin
      addr_err <= 1'b0;
      if (redir_take) begin
        pc        <= redir_misaligned ? EXC_VECTOR : redir_target;
        addr_err  <= redir_misaligned;
        if_valid  <= 1'b0;
        drop_addr <= imem_addr;
        drop_pending <= imem_req && !imem_ready;
      end else begin
        if (drop_pending && imem_req && imem_ready) drop_pending <= 1'b0;
        if (accept) begin
          if_valid    <= 1'b1;
          if_instr    <= imem_rdata;
          if_pc       <= pc;
          if_pc_plus4 <= pc_plus4;
          pc          <= pc_plus4;
        end else if (id_ready) begin
          if_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        id_ready;
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [31:0] redir_pc_plus4;
  logic [15:0] redir_imm;
  logic [25:0] redir_index;
  logic [31:0] redir_jr;
  logic        exc_req;
  logic        addr_err;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .id_ready       (id_ready),
    .redir_valid    (redir_valid),
    .redir_type     (redir_type),
    .redir_pc_plus4 (redir_pc_plus4),
    .redir_imm      (redir_imm),
    .redir_index    (redir_index),
    .redir_jr       (redir_jr),
    .exc_req        (exc_req),
    .addr_err       (addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h3C00_00A5;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_redir();
    redir_valid = 1'b0;
    exc_req     = 1'b0;
    redir_type  = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
    redir_valid = 1'b0; redir_type = 2'b00; redir_pc_plus4 = 32'h0; redir_imm = 16'h0;
    redir_index = 26'h0; redir_jr = 32'h0; exc_req = 1'b0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", if_valid); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_addr_err: got %b want 0", addr_err); end
    checks++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL rst_buf: got %h/%h/%h want 0/0/0", if_instr, if_pc, if_pc_plus4); end
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL boot_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream();
    imem_ready = 1'b1; id_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      imem_rdata = word(32'(4 * i));
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin errors++; $display("[TB] FAIL stream_addr%0d: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i)); end
      if (i > 0) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 1)) || if_instr !== word(32'(4 * (i - 1)))) begin errors++; $display("[TB] FAIL stream_buf%0d: got v=%b pc=%h instr=%h want v=1 pc=%h", i, if_valid, if_pc, if_instr, 32'(4 * (i - 1))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    imem_rdata = word(32'hC); id_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b want 0", imem_req); end
    checks++; if (if_pc !== 32'h8 || if_instr !== word(32'h8) || if_pc_plus4 !== 32'hC) begin errors++; $display("[TB] FAIL stall_buf: got pc=%h instr=%h p4=%h want pc=8", if_pc, if_instr, if_pc_plus4); end
    tick();
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8) begin errors++; $display("[TB] FAIL hold: got req=%b v=%b pc=%h want req=0 v=1 pc=8", imem_req, if_valid, if_pc); end
    id_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_req: got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL resume: got req=%b addr=%h v=%b want req=1 addr=c v=0", imem_req, imem_addr, if_valid); end
  endtask

  task automatic test_branch_drop();
    for (logic [31:0] a = 32'hC; a < 32'h20; a += 32'h4) begin
      imem_rdata = word(a);
      #1;
      checks++; if (imem_addr !== a) begin errors++; $display("[TB] FAIL walk_addr: got %h want %h", imem_addr, a); end
      tick();
    end
    imem_ready = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_pc !== 32'h1C) begin errors++; $display("[TB] FAIL br_setup: got req=%b addr=%h pc=%h want 1/20/1c", imem_req, imem_addr, if_pc); end
    tick();
    redir_valid = 1'b1; redir_type = 2'b00; redir_pc_plus4 = 32'h100; redir_imm = 16'hFFFC;
    #1;
    tick();
    clear_redir();
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL br_held: got req=%b addr=%h v=%b want 1/20/0", imem_req, imem_addr, if_valid); end
    imem_ready = 1'b1; imem_rdata = word(32'h20);
    #1;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'hF0 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL br_discard: got v=%b addr=%h req=%b want 0/f0/1", if_valid, imem_addr, imem_req); end
    imem_rdata = word(32'hF0);
    #1;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hF0 || if_instr !== word(32'hF0)) begin errors++; $display("[TB] FAIL br_target: got v=%b pc=%h instr=%h want pc=f0", if_valid, if_pc, if_instr); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL br_addr_err: got %b want 0", addr_err); end
  endtask

  task automatic test_exc_priority();
    exc_req = 1'b1; redir_valid = 1'b1; redir_type = 2'b01; redir_index = 26'h10;
    redir_pc_plus4 = 32'h104; imem_rdata = word(32'hF4);
    #1;
    tick();
    clear_redir();
    #1;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h8000_0180 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL exc_redirect: got v=%b addr=%h req=%b want 0/80000180/1", if_valid, imem_addr, imem_req); end
    imem_rdata = word(32'h8000_0180);
    #1;
    tick();
    checks++; if (if_pc !== 32'h8000_0180 || if_pc_plus4 !== 32'h8000_0184 || imem_addr !== 32'h8000_0184) begin errors++; $display("[TB] FAIL exc_fetch: got pc=%h p4=%h addr=%h want 80000180/80000184/80000184", if_pc, if_pc_plus4, imem_addr); end
  endtask

  task automatic test_jr_misaligned();
    redir_valid = 1'b1; redir_type = 2'b10; redir_jr = 32'h0000_0102; imem_ready = 1'b0;
    #1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("[TB] FAIL jr_pre_err: got %b want 0", addr_err); end
    tick();
    clear_redir();
    #1;
    checks++; if (addr_err !== 1'b1 || if_valid !== 1'b0 || imem_addr !== 32'h8000_0184) begin errors++; $display("[TB] FAIL jr_err: got err=%b v=%b addr=%h want 1/0/80000184", addr_err, if_valid, imem_addr); end
    tick();
    checks++; if (addr_err !== 1'b0 || imem_addr !== 32'h8000_0184) begin errors++; $display("[TB] FAIL jr_pulse: got err=%b addr=%h want 0/80000184", addr_err, imem_addr); end
    imem_ready = 1'b1; imem_rdata = word(32'h8000_0184);
    #1;
    tick();
    checks++; if (imem_addr !== 32'h8000_0180 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL jr_vector: got addr=%h v=%b want 80000180/0", imem_addr, if_valid); end
    imem_rdata = word(32'h8000_0180);
    #1;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8000_0180 || if_instr !== word(32'h8000_0180)) begin errors++; $display("[TB] FAIL jr_fetch: got v=%b pc=%h instr=%h want pc=80000180", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_wrap();
    redir_valid = 1'b1; redir_type = 2'b10; redir_jr = 32'hFFFF_FFFC;
    #1;
    tick();
    clear_redir();
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || addr_err !== 1'b0) begin errors++; $display("[TB] FAIL wrap_target: got addr=%h err=%b want fffffffc/0", imem_addr, addr_err); end
    imem_rdata = word(32'hFFFF_FFFC);
    #1;
    tick();
    checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap: got pc=%h p4=%h addr=%h want fffffffc/0/0", if_pc, if_pc_plus4, imem_addr); end
  endtask

  task automatic test_reserved();
    redir_valid = 1'b1; redir_type = 2'b11; redir_jr = 32'h200; imem_rdata = word(32'h0);
    #1;
    tick();
    clear_redir();
    #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL reserved: got v=%b pc=%h addr=%h want 1/0/4", if_valid, if_pc, imem_addr); end
  endtask

  task automatic test_async_reset();
    redir_valid = 1'b1; redir_type = 2'b10; redir_jr = 32'h3C;
    #1;
    tick();
    clear_redir();
    imem_rdata = word(32'h3C);
    #1;
    tick();
    checks++; if (imem_addr !== 32'h40 || if_valid !== 1'b1 || if_pc !== 32'h3C) begin errors++; $display("[TB] FAIL pre_reset: got addr=%h v=%b pc=%h want 40/1/3c", imem_addr, if_valid, if_pc); end
    imem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_clear: got req=%b v=%b want 0/0", imem_req, if_valid); end
    checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL async_buf: got %h/%h/%h want 0/0/0", if_pc, if_instr, if_pc_plus4); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reboot_req: got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reboot_addr: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_drop();
    test_exc_priority();
    test_jr_misaligned();
    test_wrap();
    test_reserved();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the program counter and sequences instruction fetch for the MIPS core.
- Issues requests to instruction memory with a req/ready handshake and buffers one returned instruction toward decode with valid/ready.
- Applies redirects: branch, jump, jump-register and exception, with exception taking priority.
- Sits between the imem port and the decode stage; replaces the free-running PC register with a stall- and flush-aware sequencer.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- EXC_VECTOR, 32'h8000_0180, exception handler address.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req  out  1  fetch request; held until imem_ready.
- imem_addr  out  32  fetch address; stable while imem_req=1.
- imem_ready  in  1  response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- if_valid  out  1  the instruction buffer holds a valid instruction.
- if_instr  out  32  buffered instruction.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc+4.
- id_ready  in  1  decode accepts the buffer this cycle.
- redir_valid  in  1  redirect request from decode/execute.
- redir_type  in  2  00 branch, 01 jump, 10 jump-register, 11 reserved (ignored).
- redir_pc_plus4  in  32  pc+4 of the redirecting instruction.
- redir_imm  in  16  branch offset, in words.
- redir_index  in  26  jump index.
- redir_jr  in  32  register target.
- exc_req  in  1  exception request.
- addr_err  out  1  one-cycle pulse when a redirect target is misaligned.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; state=BOOT.
  - imem_req=0, if_valid=0, addr_err=0, drop_pending=0.
  - if_instr, if_pc and if_pc_plus4 are 0.
- States:
  - BOOT: one cycle after reset release, imem_req=0; then go to FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: buffer full, decode stalled, no request outstanding.
- Response acceptance (FETCH):
  - Accept when imem_ready & (!if_valid | id_ready) & !drop_pending.
  - On acceptance: load the buffer with {imem_rdata, pc, pc+4}, set pc=pc+4, and stay in FETCH so a new request is issued the next cycle.
  - Throughput: 1 instruction per cycle when imem_ready is held high.
- Buffer full while a response arrives (if_valid & !id_ready):
  - The response cannot be dropped because the request is already complete.
  - Therefore issue a request only when (!if_valid | id_ready) at the request cycle.
  - Otherwise drop imem_req and go to HOLD (imem_req=0 in HOLD).
  - HOLD -> FETCH when id_ready=1.
- Buffer drain: if_valid clears on id_ready unless it is reloaded in the same cycle.
- Target computation (combinational, from redirect inputs):
  - Branch: redir_pc_plus4 + {{14{imm[15]}}, imm, 2'b00}, 32-bit wrap-around.
  - Jump: {redir_pc_plus4[31:28], index, 2'b00}.
  - Jump-register: redir_jr.
  - Exception: EXC_VECTOR.
- Redirect effect, applied on the edge where exc_req|redir_valid is sampled:
  - pc=target; if_valid=0 (flush).
  - If a request is outstanding (FETCH, imem_req=1, imem_ready=0): keep imem_addr unchanged and set drop_pending=1. The next imem_ready is consumed and discarded; drop_pending clears; the fetch of the new pc starts the following cycle.
  - If imem_ready=1 in the redirect cycle: discard that response, with no drop_pending.
  - Next state is FETCH.
- Priority: exc_req > redir_valid. A simultaneous id_ready is a don't-care (the buffer is flushed).
- Misaligned target (jump-register target[1:0]≠0):
  - addr_err pulses for 1 cycle.
  - pc=EXC_VECTOR instead of the target.
- redir_type=11 without exc_req: no effect.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 0.

Decomposition:
- Shared package mips_pkg:
  - Redirect type encodings REDIR_BR/REDIR_J/REDIR_JR.
  - Fetch state enum BOOT/FETCH/HOLD.
  - Default RESET_PC and EXC_VECTOR constants.
- One combinational sub-module, pc_target_calc: redirect inputs -> 32-bit target plus misaligned flag.
- The FSM, pc register and buffer stay in pc_fetch_ctrl.

Test Plan:
- Reset then imem_ready=1 constantly, id_ready=1 -> imem_addr 0, 4, 8, … one per cycle from the 2nd cycle after release; if_pc trails the fetch address by 1 cycle.
- id_ready=0 while if_valid with if_pc=8 -> imem_req drops to 0 and the buffer holds 8. Then id_ready=1 -> request for 0xC resumes the next cycle.
- Branch with redir_pc_plus4=0x100, imm=16'hFFFC during an outstanding fetch of 0x20 -> the 0x20 response is discarded and the next request is to 0xF0.
- exc_req and a jump (index 0x10) in the same cycle -> next imem_addr=0x8000_0180; no jump target is ever fetched.
- Jump-register with redir_jr=0x0000_0102 -> addr_err pulses once; next imem_addr=0x8000_0180.
- Assert reset mid-FETCH with pc=0x40 -> outputs clear immediately (async); after release, the first request is to RESET_PC.
